// File: rtl/pcileech_ft601_pkg.sv
// Shared FT601 framing constants: filler word, control-word marker, field positions, type codes.
// Used by the receive deframer and the transmit-side filler insertion.
package pcileech_ft601_pkg;

  localparam logic [31:0] FILLER_DWORD = 32'h66665555;
  localparam logic [7:0]  CTRL_MARKER  = 8'h77;

  localparam int CTRL_MARKER_MSB = 31;
  localparam int CTRL_MARKER_LSB = 24;
  localparam int CTRL_TYPE_MSB   = 23;
  localparam int CTRL_TYPE_LSB   = 20;
  localparam int CTRL_TLP_LAST   = 16;

  typedef enum logic [3:0] {
    TYPE_NOP = 4'h0,
    TYPE_TLP = 4'h1,
    TYPE_CFG = 4'h3
  } ctrl_type_e;

  typedef enum logic {
    S_PAYLOAD = 1'b0,
    S_CONTROL = 1'b1
  } rx_state_e;

endpackage

// File: rtl/pcileech_ft601_rx_deframer.sv
// FT601 RX deframer: payload/control DWORD pairs -> TLP stream or 64-bit config command.
// Outputs registered, 1 cycle after the control beat; no backpressure, every rx_valid beat is consumed.
module pcileech_ft601_rx_deframer #(
  parameter int PARAM_TIMEOUT_CYCLES = 1024,
  parameter int PARAM_MAX_TLP_DW     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic [31:0] tlp_data,
  output logic        tlp_last,
  output logic        tlp_valid,
  output logic [63:0] cfg_data,
  output logic        cfg_valid,
  output logic [15:0] err_count,
  output logic        sync_lost
);
  import pcileech_ft601_pkg::*;

  localparam int IDLE_W = (PARAM_TIMEOUT_CYCLES > 1) ? $clog2(PARAM_TIMEOUT_CYCLES) : 1;
  localparam int TLPC_W = (PARAM_MAX_TLP_DW > 1) ? $clog2(PARAM_MAX_TLP_DW) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(PARAM_TIMEOUT_CYCLES - 1);
  localparam logic [TLPC_W-1:0] TLPC_LAST = TLPC_W'(PARAM_MAX_TLP_DW - 1);

  rx_state_e          state_q, state_d;
  logic [31:0]        payload_q, payload_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [TLPC_W-1:0]  tlp_cnt_q, tlp_cnt_d;
  logic [31:0]        tlp_data_q, tlp_data_d;
  logic               tlp_last_q, tlp_last_d;
  logic               tlp_valid_q, tlp_valid_d;
  logic [63:0]        cfg_data_q, cfg_data_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [15:0]        err_count_q, err_count_d;
  logic               sync_lost_q, sync_lost_d;
  logic               err_inc;

  logic [7:0] ctrl_marker;
  logic [3:0] ctrl_type;
  logic       ctrl_last;
  logic       tlp_forced;

  assign ctrl_marker = rx_data[CTRL_MARKER_MSB:CTRL_MARKER_LSB];
  assign ctrl_type   = rx_data[CTRL_TYPE_MSB:CTRL_TYPE_LSB];
  assign ctrl_last   = rx_data[CTRL_TLP_LAST];
  assign tlp_forced  = (tlp_cnt_q == TLPC_LAST);

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    idle_d      = idle_q;
    tlp_cnt_d   = tlp_cnt_q;
    tlp_data_d  = tlp_data_q;
    tlp_last_d  = 1'b0;
    tlp_valid_d = 1'b0;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = 1'b0;
    sync_lost_d = 1'b0;
    err_inc     = 1'b0;

    case (state_q)
      S_PAYLOAD: begin
        if (rx_valid && (rx_data != FILLER_DWORD)) begin
          payload_d = rx_data;
          idle_d    = '0;
          state_d   = S_CONTROL;
        end
      end

      S_CONTROL: begin
        // An arriving beat always beats the timeout in the same cycle.
        if (rx_valid) begin
          state_d = S_PAYLOAD;
          idle_d  = '0;
          if (ctrl_marker != CTRL_MARKER) begin
            err_inc     = 1'b1;
            sync_lost_d = 1'b1;
          end else if (ctrl_type == TYPE_TLP) begin
            tlp_valid_d = 1'b1;
            tlp_data_d  = payload_q;
            tlp_last_d  = ctrl_last | tlp_forced;
            err_inc     = tlp_forced & ~ctrl_last;
            tlp_cnt_d   = tlp_last_d ? '0 : tlp_cnt_q + TLPC_W'(1);
          end else if (ctrl_type == TYPE_CFG) begin
            cfg_valid_d = 1'b1;
            cfg_data_d  = {payload_q, rx_data};
          end else if (ctrl_type != TYPE_NOP) begin
            err_inc     = 1'b1;
            sync_lost_d = 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d     = S_PAYLOAD;
          idle_d      = '0;
          err_inc     = 1'b1;
          sync_lost_d = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      default: state_d = S_PAYLOAD;
    endcase

    err_count_d = (err_inc && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PAYLOAD;
      payload_q   <= '0;
      idle_q      <= '0;
      tlp_cnt_q   <= '0;
      tlp_data_q  <= '0;
      tlp_last_q  <= 1'b0;
      tlp_valid_q <= 1'b0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      err_count_q <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      idle_q      <= idle_d;
      tlp_cnt_q   <= tlp_cnt_d;
      tlp_data_q  <= tlp_data_d;
      tlp_last_q  <= tlp_last_d;
      tlp_valid_q <= tlp_valid_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      err_count_q <= err_count_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign tlp_data  = tlp_data_q;
  assign tlp_last  = tlp_last_q;
  assign tlp_valid = tlp_valid_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign err_count = err_count_q;
  assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_pcileech_ft601_rx_deframer.sv
// Directed bench for the FT601 RX deframer: timeout 16 cycles, max TLP length 4 DWORDs.
module tb_pcileech_ft601_rx_deframer;

  localparam int TIMEOUT = 16;
  localparam int MAX_DW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] tlp_data;
  logic        tlp_last;
  logic        tlp_valid;
  logic [63:0] cfg_data;
  logic        cfg_valid;
  logic [15:0] err_count;
  logic        sync_lost;

  int n_assert = 0;
  int n_fail   = 0;

  pcileech_ft601_rx_deframer #(
    .PARAM_TIMEOUT_CYCLES(TIMEOUT),
    .PARAM_MAX_TLP_DW(MAX_DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tlp_data(tlp_data),
    .tlp_last(tlp_last),
    .tlp_valid(tlp_valid),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .err_count(err_count),
    .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge; outputs read right after a call reflect the previous rising edge.
  task automatic beat(input logic [31:0] d);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    bit early;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_tlp_valid", tlp_valid, 0);
    chk("rst_tlp_data", tlp_data, 0);
    chk("rst_tlp_last", tlp_last, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_cfg_data", cfg_data, 0);
    chk("rst_err", err_count, 0);
    chk("rst_sync", sync_lost, 0);
    rst = 1'b0;

    // Single TLP pair with last set
    beat(32'h12345678);
    beat(32'h77110000);
    idle();
    chk("tlp1_valid", tlp_valid, 1);
    chk("tlp1_data", tlp_data, 32'h12345678);
    chk("tlp1_last", tlp_last, 1);
    chk("tlp1_cfg_valid", cfg_valid, 0);
    chk("tlp1_err", err_count, 0);
    idle();
    chk("tlp1_pulse_end", tlp_valid, 0);

    // Filler between pairs, then a config command
    for (int i = 0; i < 5; i++) beat(32'h66665555);
    beat(32'hAABBCCDD);
    beat(32'h77300000);
    idle();
    chk("cfg_valid", cfg_valid, 1);
    chk("cfg_data", cfg_data, 64'hAABBCCDD_77300000);
    chk("cfg_tlp_valid", tlp_valid, 0);
    chk("cfg_err", err_count, 0);
    idle();
    chk("cfg_pulse_end", cfg_valid, 0);

    // Bad marker
    beat(32'h00000001);
    beat(32'h55100000);
    idle();
    chk("badmk_sync", sync_lost, 1);
    chk("badmk_err", err_count, 1);
    chk("badmk_tlp_valid", tlp_valid, 0);
    chk("badmk_cfg_valid", cfg_valid, 0);
    beat(32'h00000022);
    beat(32'h77110000);
    idle();
    chk("after_bad_tlp_valid", tlp_valid, 1);
    chk("after_bad_tlp_data", tlp_data, 32'h22);
    chk("after_bad_sync", sync_lost, 0);

    // Filler in the control slot fails the marker check
    beat(32'h00000005);
    beat(32'h66665555);
    idle();
    chk("fillctl_sync", sync_lost, 1);
    chk("fillctl_err", err_count, 2);

    // Unknown type code
    beat(32'h00000006);
    beat(32'h77200000);
    idle();
    chk("badtype_sync", sync_lost, 1);
    chk("badtype_err", err_count, 3);
    chk("badtype_tlp_valid", tlp_valid, 0);

    // NOP dropped silently
    beat(32'h00000007);
    beat(32'h77000000);
    idle();
    chk("nop_sync", sync_lost, 0);
    chk("nop_err", err_count, 3);
    chk("nop_tlp_valid", tlp_valid, 0);
    chk("nop_cfg_valid", cfg_valid, 0);

    // Timeout on a stalled half-pair
    do_reset();
    beat(32'h00000009);
    early = 1'b0;
    for (int i = 0; i < 14; i++) begin
      idle();
      if (sync_lost) early = 1'b1;
    end
    chk("timeout_not_early", early, 0);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      idle();
      if (sync_lost) seen = 1'b1;
    end
    chk("timeout_sync_seen", seen, 1);
    chk("timeout_err", err_count, 1);
    beat(32'h0000000A);
    beat(32'h77110000);
    idle();
    chk("post_to_tlp_valid", tlp_valid, 1);
    chk("post_to_tlp_data", tlp_data, 32'hA);
    chk("post_to_err", err_count, 1);

    // Forced end-of-packet at 4 DWORDs, back-to-back pairs
    do_reset();
    beat(32'h00000100);
    for (int i = 0; i < 5; i++) begin
      beat(32'h77100000);
      if (i < 4) beat(32'h00000101 + i);
      else idle();
      chk($sformatf("max_valid%0d", i), tlp_valid, 1);
      chk($sformatf("max_data%0d", i), tlp_data, 32'h100 + i);
      chk($sformatf("max_last%0d", i), tlp_last, (i == 3) ? 1 : 0);
      chk($sformatf("max_err%0d", i), err_count, (i >= 3) ? 1 : 0);
    end

    // Async reset while holding a payload in the control state
    beat(32'h00000044);
    beat(32'h77110000);
    beat(32'h00000033);
    chk("pre_rst_data", tlp_data, 32'h44);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tlp_data", tlp_data, 0);
    chk("arst_err", err_count, 0);
    chk("arst_tlp_valid", tlp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beat(32'h00000055);
    beat(32'h77110000);
    idle();
    chk("post_arst_valid", tlp_valid, 1);
    chk("post_arst_data", tlp_data, 32'h55);
    chk("post_arst_err", err_count, 0);
    chk("post_arst_sync", sync_lost, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcileech_ft601_rx_deframer.md
# pcileech_ft601_rx_deframer

- Receive-side deframer between the FT601 controller's 32-bit output stream and the FIFO controller.
- Consumes host-to-device DWORDs in payload/control pairs and discards FTDI filler words (0x66665555).
- Validates each control word and routes the payload onto a TLP stream (with end-of-packet marking) or a 64-bit configuration stream.
- Counts framing errors and resynchronises after stalled half-pairs. It mirrors the transmit path, which inserts filler and serialises 256-bit words to 32 bits.

## Interface
Parameters:
- PARAM_TIMEOUT_CYCLES, 1024, idle cycles after which a pending payload DWORD is discarded
- PARAM_MAX_TLP_DW, 1024, maximum TLP length in DWORDs before a forced end-of-packet

Ports:
- clk  in  1  system clock (100 MHz); one clock, all logic synchronous to it
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  32  DWORD from FT601 controller
- rx_valid  in  1  rx_data valid this cycle; no backpressure, must be accepted
- tlp_data  out  32  TLP DWORD
- tlp_last  out  1  final DWORD of TLP
- tlp_valid  out  1  tlp_data/tlp_last valid, single-cycle pulse
- cfg_data  out  64  {payload, control} config command
- cfg_valid  out  1  cfg_data valid, single-cycle pulse
- err_count  out  16  saturating framing-error counter
- sync_lost  out  1  pulse on timeout discard or bad control word

## Operation
Control word fields:
- [31:24] marker, must be 0x77
- [23:20] type: 0x1 = TLP, 0x3 = CFG, 0x0 = NOP
- [16] TLP last
- all other bits ignored

States:
- S_PAYLOAD (reset state):
  - rx_valid with rx_data == 0x66665555: drop the word, stay.
  - Other rx_valid: latch payload, clear idle counter, go to S_CONTROL.
- S_CONTROL:
  - rx_valid: decode the word as control and return to S_PAYLOAD. Filler is NOT special here; 0x66665555 fails the marker check.
  - Marker != 0x77, or type not in {0x0, 0x1, 0x3}: drop the pair, err_count += 1, pulse sync_lost.
  - Type 0x1: emit payload on the TLP stream. tlp_last = bit16 OR (tlp_dw_count == PARAM_MAX_TLP_DW-1). A forced last (bit16 clear) also increments err_count. tlp_dw_count resets to 0 after any last.
  - Type 0x3: cfg_data = {payload, control}, pulse cfg_valid.
  - Type 0x0: drop silently.
  - No rx_valid: increment the idle counter. When it reaches PARAM_TIMEOUT_CYCLES-1, discard the payload, pulse sync_lost, err_count += 1, return to S_PAYLOAD.

Counters and widths:
- err_count saturates at 0xFFFF.
- tlp_dw_count and the idle counter are sized with $clog2 of their parameter and never wrap: each is cleared before reaching its terminal value.

## Timing
- Reset values: all outputs 0; state S_PAYLOAD; all counters 0.
- Reset mid-pair discards the latched payload without counting an error.
- Latency: outputs assert exactly 1 cycle after the control-word beat (registered outputs).
- Throughput: one pair per two rx_valid beats, back-to-back with no bubble. Pulses from consecutive pairs may be 2 cycles apart.
- tlp_valid and cfg_valid are never high in the same cycle.
- Timeout and an arriving rx_valid in the same cycle: rx_valid wins and the pair is decoded normally.
- Outputs are not held; downstream must capture on the valid pulse.

## Structure
- Shared package pcileech_ft601_pkg holds:
  - FILLER_DWORD = 32'h66665555 (shared with the transmit-side filler insertion)
  - CTRL_MARKER = 8'h77
  - type codes TYPE_NOP / TYPE_TLP / TYPE_CFG
  - control-word field position constants
- Single module, no sub-module. The idle-timeout counter is inline.
- Estimated 150-250 lines.

## Test plan
- Pair 0x12345678, 0x77110000 -> 1 cycle later tlp_valid = 1, tlp_data = 0x12345678, tlp_last = 1. err_count stays 0.
- Five 0x66665555 words, then pair 0xAABBCCDD, 0x77300000 -> filler dropped; cfg_valid pulses once with cfg_data = 0xAABBCCDD_77300000.
- Pair 0x1, 0x55100000 (bad marker) -> no output, sync_lost pulse, err_count = 1. Following good TLP pair decoded correctly.
- Payload 0x9, then no rx_valid for PARAM_TIMEOUT_CYCLES -> sync_lost, err_count = 1. Next pair 0xA, 0x77110000 emits tlp_data = 0xA.
- PARAM_MAX_TLP_DW = 4, five TLP pairs with bit16 clear:
  - 4th emitted with tlp_last = 1 and err_count = 1
  - 5th starts a new TLP with tlp_last = 0
- rst asserted asynchronously while in S_CONTROL -> outputs 0 immediately. After release, a fresh pair decodes; err_count = 0.
